// File: rtl/ble_fifo_wr_ctrl.sv
// ble_fifo_wr_ctrl
// ----------------
// Write-side controller for the BLE PHY asynchronous sample FIFO.
// Arbitrates round-robin between producer A (modulator samples) and
// producer B (register-path writes), drives the dual-port RAM write port,
// keeps the binary and Gray write pointers, and derives full / almost-full /
// fill level in the W_CLK domain from the synchronized Gray read pointer.
//
// Optional feature macro: BLE_WFIFO_LEVEL_EN
//   defined   -> w_level and w_afull are computed (Gray decoder compiled in)
//   undefined -> w_level and w_afull are tied to 0
//
// Ports
//   W_CLK, W_rst_n   write clock, asynchronous active-low reset
//   req_a/req_b      producer requests (held with data until granted)
//   data_a/data_b    producer data
//   gnt_a/gnt_b      combinational accept; word is written at this edge
//   wq2_rptr         Gray read pointer, already synchronized into W_CLK
//   w_ptr            registered Gray write pointer (to read-side sync)
//   w_addr           RAM write address (binary pointer LSBs)
//   w_data           RAM write data
//   w_en             RAM write enable (gnt_a | gnt_b)
//   w_full           registered full flag
//   w_afull          registered almost-full flag
//   w_level          registered fill level
module ble_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                  W_CLK,
  input  logic                  W_rst_n,
  input  logic                  req_a,
  input  logic                  req_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  gnt_a,
  output logic                  gnt_b,
  input  logic [ADDR_WIDTH:0]   wq2_rptr,
  output logic [ADDR_WIDTH:0]   w_ptr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_en,
  output logic                  w_full,
  output logic                  w_afull,
  output logic [ADDR_WIDTH:0]   w_level
);

  localparam int PW = ADDR_WIDTH + 1;

  // Binary to reflected-binary Gray conversion.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

`ifdef BLE_WFIFO_LEVEL_EN
  // Gray to binary conversion: each binary bit is the XOR of all Gray bits above and at it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction
`endif

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic          prio_q, prio_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic [PW-1:0] level_q, level_d;
  logic          gnt_a_s, gnt_b_s, w_en_s;
  logic [PW-1:0] full_tgt_s;

  // Round-robin arbitration; grants are also suppressed while reset is held
  // so no write is accepted in the cycle reset releases asynchronously.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    if (W_rst_n && !full_q) begin
      if (req_a && req_b) begin
        if (prio_q) begin
          gnt_b_s = 1'b1;
        end else begin
          gnt_a_s = 1'b1;
        end
      end else if (req_a) begin
        gnt_a_s = 1'b1;
      end else if (req_b) begin
        gnt_b_s = 1'b1;
      end else begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
      end
    end else begin
      gnt_a_s = 1'b0;
      gnt_b_s = 1'b0;
    end
  end

  assign w_en_s = gnt_a_s | gnt_b_s;

  // Next-state for priority, pointers and flags.
  always_comb begin
    prio_d     = prio_q;
    wbin_d     = wbin_q;
    wgray_d    = wgray_q;
    full_d     = 1'b0;
    afull_d    = 1'b0;
    level_d    = {PW{1'b0}};
    full_tgt_s = {PW{1'b0}};

    if (gnt_a_s) begin
      prio_d = 1'b1;
    end else if (gnt_b_s) begin
      prio_d = 1'b0;
    end else begin
      prio_d = prio_q;
    end

    if (w_en_s) begin
      wbin_d = wbin_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wbin_d = wbin_q;
    end
    wgray_d = bin2gray(wbin_d);

    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray code that is the read pointer with its two MSBs inverted.
    full_tgt_s = {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]};
    full_d     = (wgray_d == full_tgt_s);

`ifdef BLE_WFIFO_LEVEL_EN
    level_d = wbin_d - gray2bin(wq2_rptr);
    afull_d = (level_d >= PW'(AFULL_LEVEL));
`else
    level_d = {PW{1'b0}};
    afull_d = 1'b0;
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge W_CLK or negedge W_rst_n) begin
    if (!W_rst_n) begin
      wbin_q  <= {PW{1'b0}};
      wgray_q <= {PW{1'b0}};
      prio_q  <= 1'b0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= {PW{1'b0}};
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      prio_q  <= prio_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      level_q <= level_d;
    end
  end

  assign gnt_a   = gnt_a_s;
  assign gnt_b   = gnt_b_s;
  assign w_en    = w_en_s;
  assign w_data  = gnt_a_s ? data_a : data_b;
  assign w_addr  = wbin_q[ADDR_WIDTH-1:0];
  assign w_ptr   = wgray_q;
  assign w_full  = full_q;
  assign w_afull = afull_q;
  assign w_level = level_q;

endmodule

// File: tb/tb_ble_fifo_wr_ctrl.sv
// Directed testbench for ble_fifo_wr_ctrl (default parameters 4/8/12).
module tb_ble_fifo_wr_ctrl;

  logic       W_CLK = 1'b0;
  logic       W_rst_n;
  logic       req_a, req_b;
  logic [7:0] data_a, data_b;
  logic       gnt_a, gnt_b;
  logic [4:0] wq2_rptr;
  logic [4:0] w_ptr;
  logic [3:0] w_addr;
  logic [7:0] w_data;
  logic       w_en, w_full, w_afull;
  logic [4:0] w_level;

  int n_pass  = 0;
  int n_total = 0;

`ifdef BLE_WFIFO_LEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  ble_fifo_wr_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .AFULL_LEVEL(12)) dut (
    .W_CLK(W_CLK), .W_rst_n(W_rst_n),
    .req_a(req_a), .req_b(req_b), .data_a(data_a), .data_b(data_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .wq2_rptr(wq2_rptr),
    .w_ptr(w_ptr), .w_addr(w_addr), .w_data(w_data), .w_en(w_en),
    .w_full(w_full), .w_afull(w_afull), .w_level(w_level)
  );

  always #5 W_CLK = ~W_CLK;

  function automatic logic [4:0] gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reset and return 1ns after a rising edge with reset released.
  task automatic reset_dut();
    W_rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0;
    data_a = 8'h00; data_b = 8'h00; wq2_rptr = 5'd0;
    repeat (2) @(posedge W_CLK);
    #1 W_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    W_rst_n = 1'b0; req_a = 1'b1; req_b = 1'b0;
    data_a = 8'h5A; data_b = 8'h00; wq2_rptr = 5'd0;
    repeat (2) @(posedge W_CLK);
    @(negedge W_CLK);
    n_total++;
    if ({gnt_a, gnt_b, w_en, w_full, w_afull} !== 5'b00000) $display("FAIL rst_flags got %b want 00000", {gnt_a, gnt_b, w_en, w_full, w_afull});
    else n_pass++;
    n_total++;
    if ({w_ptr, w_addr, w_level} !== 14'd0) $display("FAIL rst_ptrs got ptr=%b addr=%0d lvl=%0d want 0", w_ptr, w_addr, w_level);
    else n_pass++;
    @(posedge W_CLK); #1 W_rst_n = 1'b1;
    @(negedge W_CLK);
    n_total++;
    if ({gnt_a, w_en, w_addr, w_data} !== {1'b1, 1'b1, 4'd0, 8'h5A}) $display("FAIL rst_first_grant got gnt_a=%b w_en=%b addr=%0d data=%h want 1 1 0 5a", gnt_a, w_en, w_addr, w_data);
    else n_pass++;
    @(posedge W_CLK); #1 req_a = 1'b0;
    @(negedge W_CLK);
    n_total++;
    if ({w_addr, w_ptr, w_en} !== {4'd1, 5'b00001, 1'b0}) $display("FAIL rst_after_write got addr=%0d ptr=%b en=%b want 1 00001 0", w_addr, w_ptr, w_en);
    else n_pass++;
  endtask

  // Fill from A with the read pointer at 0, then release one slot.
  task automatic test_fill_release();
    reset_dut();
    req_a = 1'b1; data_a = 8'd0;
    for (int i = 0; i < 16; i++) begin
      @(negedge W_CLK);
      n_total++;
      if ({gnt_a, gnt_b, w_full, w_addr, w_data} !== {1'b1, 1'b0, 1'b0, 4'(i), 8'(i)})
        $display("FAIL fill_step%0d got gnt_a=%b gnt_b=%b full=%b addr=%0d data=%0d want 1 0 0 %0d %0d", i, gnt_a, gnt_b, w_full, w_addr, w_data, i, i);
      else n_pass++;
      n_total++;
      if ({w_level, w_afull} !== {(LVL ? 5'(i) : 5'd0), (LVL && i >= 12)})
        $display("FAIL fill_level%0d got lvl=%0d afull=%b want %0d %b", i, w_level, w_afull, (LVL ? i : 0), (LVL && i >= 12));
      else n_pass++;
      @(posedge W_CLK); #1 data_a = 8'(i + 1);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge W_CLK);
      n_total++;
      if ({w_full, gnt_a, w_en, w_ptr, w_addr} !== {1'b1, 1'b0, 1'b0, 5'b11000, 4'd0})
        $display("FAIL fill_full%0d got full=%b gnt_a=%b en=%b ptr=%b addr=%0d want 1 0 0 11000 0", k, w_full, gnt_a, w_en, w_ptr, w_addr);
      else n_pass++;
      n_total++;
      if ({w_level, w_afull} !== {(LVL ? 5'd16 : 5'd0), LVL})
        $display("FAIL full_level got lvl=%0d afull=%b want %0d %b", w_level, w_afull, (LVL ? 16 : 0), LVL);
      else n_pass++;
      @(posedge W_CLK); #1;
    end
    wq2_rptr = 5'b00001;
    @(negedge W_CLK);
    n_total++;
    if ({w_full, gnt_a} !== 2'b10) $display("FAIL rel_lag got full=%b gnt_a=%b want 1 0", w_full, gnt_a);
    else n_pass++;
    @(posedge W_CLK); #1;
    @(negedge W_CLK);
    n_total++;
    if ({w_full, gnt_a, w_addr} !== {1'b0, 1'b1, 4'd0}) $display("FAIL rel_open got full=%b gnt_a=%b addr=%0d want 0 1 0", w_full, gnt_a, w_addr);
    else n_pass++;
    @(posedge W_CLK); #1;
    @(negedge W_CLK);
    n_total++;
    if ({w_full, gnt_a, w_ptr} !== {1'b1, 1'b0, 5'b11001}) $display("FAIL rel_refull got full=%b gnt_a=%b ptr=%b want 1 0 11001", w_full, gnt_a, w_ptr);
    else n_pass++;
    n_total++;
    if (w_level !== (LVL ? 5'd16 : 5'd0)) $display("FAIL rel_level got %0d want %0d", w_level, (LVL ? 16 : 0));
    else n_pass++;
    req_a = 1'b0;
  endtask

  task automatic test_contention();
    logic exp_a;
    reset_dut();
    req_a = 1'b1; req_b = 1'b1; data_a = 8'hAA; data_b = 8'hBB;
    for (int i = 0; i < 6; i++) begin
      exp_a = (i % 2 == 0);
      @(negedge W_CLK);
      n_total++;
      if ({gnt_a, gnt_b, w_addr, w_data} !== {exp_a, ~exp_a, 4'(i), (exp_a ? 8'hAA : 8'hBB)})
        $display("FAIL contend%0d got gnt_a=%b gnt_b=%b addr=%0d data=%h want %b %b %0d %h", i, gnt_a, gnt_b, w_addr, w_data, exp_a, ~exp_a, i, (exp_a ? 8'hAA : 8'hBB));
      else n_pass++;
      @(posedge W_CLK); #1;
    end
    req_a = 1'b0;
    for (int i = 6; i < 9; i++) begin
      @(negedge W_CLK);
      n_total++;
      if ({gnt_a, gnt_b, w_en, w_addr, w_data} !== {1'b0, 1'b1, 1'b1, 4'(i), 8'hBB})
        $display("FAIL only_b%0d got gnt_a=%b gnt_b=%b en=%b addr=%0d data=%h want 0 1 1 %0d bb", i, gnt_a, gnt_b, w_en, w_addr, w_data, i);
      else n_pass++;
      @(posedge W_CLK); #1;
    end
    req_b = 1'b0;
  endtask

  task automatic test_wrap();
    logic [4:0] prev;
    logic [4:0] n;
    reset_dut();
    req_a = 1'b1; data_a = 8'h3C;
    n = 5'd0; prev = 5'd0;
    for (int i = 0; i < 40; i++) begin
      wq2_rptr = (i >= 2) ? gray(5'(i - 2)) : 5'd0;
      @(negedge W_CLK);
      n_total++;
      if ({gnt_a, w_full, w_addr, w_ptr} !== {1'b1, 1'b0, n[3:0], gray(n)})
        $display("FAIL wrap%0d got gnt_a=%b full=%b addr=%0d ptr=%b want 1 0 %0d %b", i, gnt_a, w_full, w_addr, w_ptr, n[3:0], gray(n));
      else n_pass++;
      if (i > 0) begin
        n_total++;
        if ($countones(w_ptr ^ prev) !== 1) $display("FAIL wrap_gray%0d got %b after %b want one-bit change", i, w_ptr, prev);
        else n_pass++;
      end
      prev = w_ptr;
      @(posedge W_CLK); #1 n = n + 5'd1;
    end
    req_a = 1'b0;
  endtask

  task automatic test_midreset();
    reset_dut();
    req_a = 1'b1; data_a = 8'h11;
    repeat (5) @(posedge W_CLK);
    @(negedge W_CLK);
    W_rst_n = 1'b0;
    #1;
    n_total++;
    if ({gnt_a, w_en, w_ptr, w_addr, w_full} !== {1'b0, 1'b0, 5'd0, 4'd0, 1'b0})
      $display("FAIL midreset got gnt_a=%b en=%b ptr=%b addr=%0d full=%b want 0 0 0 0 0", gnt_a, w_en, w_ptr, w_addr, w_full);
    else n_pass++;
    req_a = 1'b0;
    @(posedge W_CLK); #1 W_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_release();
    test_contention();
    test_wrap();
    test_midreset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
